// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code encoding and default data path width.
package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_SHL    = 3'b101,
    OP_SHR    = 3'b110,
    OP_PASS_A = 3'b111
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/operation request and registered result/flag bundle of the ALU.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
);

  logic             in_valid;
  logic             carry_in;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  alu_op_e          operation;

  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             flag_carry;
  logic             flag_overflow;
  logic             flag_zero;
  logic             flag_neg;

  modport master (
    output in_valid, carry_in, input_a, input_b, operation,
    input  out_valid, alu_out, flag_carry, flag_overflow, flag_zero, flag_neg
  );

  modport slave (
    input  in_valid, carry_in, input_a, input_b, operation,
    output out_valid, alu_out, flag_carry, flag_overflow, flag_zero, flag_neg
  );

endinterface : alu_if

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor; subtraction is A + ~B + 1 so carry means "no borrow".
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             subtract_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] b_op_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;

  // Operand conditioning, (WIDTH+1)-bit sum and signed overflow detection
  always_comb begin
    b_op_s     = {WIDTH{1'b0}};
    cin_s      = 1'b0;
    sum_s      = {(WIDTH+1){1'b0}};
    overflow_o = 1'b0;
    if (subtract_i) begin
      b_op_s = ~b_i;
      cin_s  = 1'b1;
    end else begin
      b_op_s = b_i;
      cin_s  = carry_i;
    end
    sum_s      = {1'b0, a_i} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
    overflow_o = (a_i[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_i[WIDTH-1]);
  end

  assign result_o = sum_s[WIDTH-1:0];
  assign carry_o  = sum_s[WIDTH];

endmodule : alu_addsub

// File: rtl/alu.sv
// Single-cycle ALU: combinational result/flags feeding one output register stage.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input logic   clk,
  input logic   rst_n,
  alu_if.slave  bus
);

  logic [WIDTH-1:0] as_result_s;
  logic             as_carry_s;
  logic             as_overflow_s;
  logic             is_sub_s;

  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             overflow_s;

  logic             valid_d,    valid_q;
  logic [WIDTH-1:0] out_d,      out_q;
  logic             carry_d,    carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_d,     zero_q;
  logic             neg_d,      neg_q;

  assign is_sub_s = (bus.operation == OP_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i        (bus.input_a),
    .b_i        (bus.input_b),
    .carry_i    (bus.carry_in),
    .subtract_i (is_sub_s),
    .result_o   (as_result_s),
    .carry_o    (as_carry_s),
    .overflow_o (as_overflow_s)
  );

  // Result and carry/overflow selection by op code
  always_comb begin
    res_s      = {WIDTH{1'b0}};
    carry_s    = 1'b0;
    overflow_s = 1'b0;
    case (bus.operation)
      OP_ADD, OP_SUB: begin
        res_s      = as_result_s;
        carry_s    = as_carry_s;
        overflow_s = as_overflow_s;
      end
      OP_AND:    res_s = bus.input_a & bus.input_b;
      OP_OR:     res_s = bus.input_a | bus.input_b;
      OP_XOR:    res_s = bus.input_a ^ bus.input_b;
      OP_SHL: begin
        res_s   = {bus.input_a[WIDTH-2:0], 1'b0};
        carry_s = bus.input_a[WIDTH-1];
      end
      OP_SHR: begin
        res_s   = {1'b0, bus.input_a[WIDTH-1:1]};
        carry_s = bus.input_a[0];
      end
      OP_PASS_A: res_s = bus.input_a;
      default: begin
        res_s      = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        overflow_s = 1'b0;
      end
    endcase
  end

  // Next state: load on in_valid, otherwise hold data and drop valid
  always_comb begin
    valid_d    = bus.in_valid;
    out_d      = out_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    if (bus.in_valid) begin
      out_d      = res_s;
      carry_d    = carry_s;
      overflow_d = overflow_s;
      zero_d     = (res_s == {WIDTH{1'b0}});
      neg_d      = res_s[WIDTH-1];
    end else begin
      out_d      = out_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      neg_d      = neg_q;
    end
  end

  // Output register stage; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      out_q      <= {WIDTH{1'b0}};
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.alu_out       = out_q;
  assign bus.flag_carry    = carry_q;
  assign bus.flag_overflow = overflow_q;
  assign bus.flag_zero     = zero_q;
  assign bus.flag_neg      = neg_q;

endmodule : alu

// File: tb/tb_alu.sv
// Directed-vector bench for alu (WIDTH=8); expectations are hand-computed.
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_if #(.WIDTH(8)) bus ();

  alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ef = {C, V, Z, N}
  task automatic check(input string tag, input logic ev, input logic [3:0] ef, input logic [7:0] eo);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {bus.out_valid, bus.flag_carry, bus.flag_overflow, bus.flag_zero, bus.flag_neg, bus.alu_out};
    exp = {ev, ef, eo};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got valid/CVZN/out=%b/%b/%h, expected %b/%b/%h",
             tag, obs[12], obs[11:8], obs[7:0], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic v, input alu_op_e op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin);
    bus.in_valid  = v;
    bus.operation = op;
    bus.input_a   = a;
    bus.input_b   = b;
    bus.carry_in  = cin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0);
    #3;
    check("reset_initial", 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, OP_ADD, 8'h02, 8'h02, 1'b0);    tick(); check("add_2_2",        1'b1, 4'b0000, 8'h04);
    drive(1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0);    tick(); check("add_wrap",       1'b1, 4'b1010, 8'h00);
    drive(1'b1, OP_ADD, 8'h7F, 8'h00, 1'b1);    tick(); check("add_cin_ovf",    1'b1, 4'b0101, 8'h80);
    drive(1'b1, OP_ADD, 8'h40, 8'h40, 1'b0);    tick(); check("add_ovf",        1'b1, 4'b0101, 8'h80);
    drive(1'b1, OP_SUB, 8'h02, 8'h02, 1'b0);    tick(); check("sub_eq",         1'b1, 4'b1010, 8'h00);
    drive(1'b1, OP_SUB, 8'h01, 8'h02, 1'b0);    tick(); check("sub_borrow",     1'b1, 4'b0001, 8'hFF);
    drive(1'b1, OP_SUB, 8'h80, 8'h01, 1'b0);    tick(); check("sub_ovf",        1'b1, 4'b1100, 8'h7F);
    drive(1'b1, OP_SUB, 8'h05, 8'h03, 1'b1);    tick(); check("sub_cin_ignored",1'b1, 4'b1000, 8'h02);
    drive(1'b1, OP_AND, 8'hFF, 8'hFE, 1'b1);    tick(); check("and",            1'b1, 4'b0001, 8'hFE);
    drive(1'b1, OP_OR,  8'h0F, 8'hF0, 1'b0);    tick(); check("or",             1'b1, 4'b0001, 8'hFF);
    drive(1'b1, OP_XOR, 8'hAA, 8'hFF, 1'b0);    tick(); check("xor",            1'b1, 4'b0000, 8'h55);
    drive(1'b1, OP_XOR, 8'h5A, 8'h5A, 1'b0);    tick(); check("xor_zero",       1'b1, 4'b0010, 8'h00);
    drive(1'b1, OP_SHL, 8'h0F, 8'h00, 1'b0);    tick(); check("shl",            1'b1, 4'b0000, 8'h1E);
    drive(1'b1, OP_SHL, 8'h81, 8'h00, 1'b0);    tick(); check("shl_carry",      1'b1, 4'b1000, 8'h02);
    drive(1'b1, OP_SHR, 8'h81, 8'h00, 1'b0);    tick(); check("shr_carry",      1'b1, 4'b1000, 8'h40);
    drive(1'b1, OP_SHR, 8'h02, 8'h00, 1'b0);    tick(); check("shr",            1'b1, 4'b0000, 8'h01);
    drive(1'b1, OP_PASS_A, 8'h80, 8'hFF, 1'b1); tick(); check("pass_a",         1'b1, 4'b0001, 8'h80);

    // idle cycle with changed operands: data holds, valid drops
    drive(1'b0, OP_ADD, 8'h11, 8'h22, 1'b1);    tick(); check("idle_hold",      1'b0, 4'b0001, 8'h80);
    drive(1'b0, OP_SUB, 8'h00, 8'h00, 1'b0);    tick(); check("idle_hold2",     1'b0, 4'b0001, 8'h80);

    // reset between edges while out_valid=1
    drive(1'b1, OP_ADD, 8'h01, 8'h01, 1'b0);    tick(); check("pre_reset",      1'b1, 4'b0000, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 1'b0, 4'b0000, 8'h00);
    tick();
    check("reset_held", 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, OP_ADD, 8'h33, 8'h44, 1'b0);    tick(); check("post_reset_idle",1'b0, 4'b0000, 8'h00);
    drive(1'b1, OP_ADD, 8'h10, 8'h20, 1'b1);    tick(); check("post_reset_add", 1'b1, 4'b0000, 8'h31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu
